// File: rtl/adv_fifo.sv
// Single-clock FIFO with registered read data, status flags and over/underrun pulses.
// Optional stored even-parity per word is enabled by defining FIFO_PARITY_EN.
module adv_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AF_LEVEL  = 14,
    parameter int unsigned AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 rd_en,
`ifdef FIFO_PARITY_EN
    input  logic                 par_inject,
    output logic                 parity_err,
`endif
    output logic [WIDTH-1:0]     data_out,
    output logic                 rd_valid,
    output logic                 wr_ack,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count
);

    localparam int unsigned PTR_W = ADDR_SIZE + 1;
`ifdef FIFO_PARITY_EN
    localparam int unsigned MEM_W = WIDTH + 1;
`else
    localparam int unsigned MEM_W = WIDTH;
`endif

    logic [MEM_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
`ifdef FIFO_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic [PTR_W-1:0] count_c;
    logic             full_c, empty_c;
    logic             wr_accept_c, rd_accept_c;
    logic [MEM_W-1:0] wr_word_c, rd_word_c;

    // Status flags derived from the registered pointers; the extra MSB separates full from empty.
    always_comb begin
        count_c = wr_ptr_q - rd_ptr_q;
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]) &&
                  (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);
    end

    assign count        = count_c;
    assign empty        = empty_c;
    assign full         = full_c;
    assign almost_full  = (count_c >= PTR_W'(AF_LEVEL));
    assign almost_empty = (count_c <= PTR_W'(AE_LEVEL));

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef FIFO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

    // Next-state: accept decisions, pointer advance and single-cycle status pulses.
    always_comb begin
        wr_accept_c  = wr_en && !full_c;
        rd_accept_c  = rd_en && !empty_c;
        rd_word_c    = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
`ifdef FIFO_PARITY_EN
        wr_word_c    = {(^data_in) ^ par_inject, data_in};
        parity_err_d = rd_accept_c && (^rd_word_c);
`else
        wr_word_c    = data_in;
`endif
        wr_ptr_d     = wr_ptr_q + PTR_W'(wr_accept_c);
        rd_ptr_d     = rd_ptr_q + PTR_W'(rd_accept_c);
        data_out_d   = rd_accept_c ? rd_word_c[WIDTH-1:0] : data_out_q;
        rd_valid_d   = rd_accept_c;
        wr_ack_d     = wr_accept_c;
        overflow_d   = wr_en && full_c;
        underflow_d  = rd_en && empty_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef FIFO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
`ifdef FIFO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Storage is never cleared; writes presented while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept_c) begin
            mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_word_c;
        end
    end

endmodule

// File: tb/tb_adv_fifo.sv
// Directed self-checking bench for adv_fifo; parity cases run when FIFO_PARITY_EN is defined.
module tb_adv_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       rd_valid, wr_ack, overflow, underflow;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
`ifdef FIFO_PARITY_EN
    logic       par_inject;
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt;

    adv_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
`ifdef FIFO_PARITY_EN
        .par_inject   (par_inject),
        .parity_err   (parity_err),
`endif
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .wr_ack       (wr_ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
`ifdef FIFO_PARITY_EN
        par_inject = 1'b0;
`endif
        step();
        step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_pulses", 32'({rd_valid, wr_ack, overflow, underflow}), 32'd0);
        rst_n = 1'b1;
        step();

        // Fill with 0x01..0x10
        ack_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(i + 1);
            step();
            if (wr_ack) ack_cnt++;
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
            check("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
            check("fill_full", 32'(full), 32'(i + 1 == 16));
        end
        check("fill_acks", 32'(ack_cnt), 32'd16);

        // Overflow on full
        data_in = 8'hAA;
        step();
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_noack", 32'(wr_ack), 32'd0);
        check("ovf_count", 32'(count), 32'd16);
        idle();
        step();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain, then one extra read
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_data", 32'(data_out), 32'(i + 1));
        end
        step();
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_valid", 32'(rd_valid), 32'd0);
        check("udf_hold", 32'(data_out), 32'h10);
        check("udf_empty", 32'(empty), 32'd1);
        idle();
        step();
        check("udf_clear", 32'(underflow), 32'd0);

        // Preload 5 then 40 cycles of simultaneous traffic across pointer wrap
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h80 + i);
            step();
        end
        check("pre_count", 32'(count), 32'd5);
        for (int k = 0; k < 40; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 8'(8'h85 + k);
            step();
            check("wrap_count", 32'(count), 32'd5);
            check("wrap_data", 32'(data_out), 32'(8'h80 + k));
            check("wrap_valid", 32'(rd_valid & wr_ack), 32'd1);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_en = 1'b1;
            step();
            check("wrap_tail", 32'(data_out), 32'(8'hA8 + k));
        end
        idle();
        step();
        check("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous on empty: write wins, read underflows
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h55;
        step();
        check("se_udf", 32'(underflow), 32'd1);
        check("se_ack", 32'(wr_ack), 32'd1);
        check("se_valid", 32'(rd_valid), 32'd0);
        check("se_count", 32'(count), 32'd1);
        wr_en = 1'b0;
        step();
        check("se_data", 32'(data_out), 32'h55);
        check("se_rvalid", 32'(rd_valid), 32'd1);
        check("se_empty", 32'(empty), 32'd1);

        // Simultaneous on full: read wins, write overflows
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h20 + i);
            step();
        end
        check("sf_full", 32'(full), 32'd1);
        rd_en   = 1'b1;
        data_in = 8'hEE;
        step();
        check("sf_ovf", 32'(overflow), 32'd1);
        check("sf_noack", 32'(wr_ack), 32'd0);
        check("sf_valid", 32'(rd_valid), 32'd1);
        check("sf_data", 32'(data_out), 32'h20);
        check("sf_count", 32'(count), 32'd15);
        wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            check("sf_drain", 32'(data_out), 32'(8'h20 + i));
        end
        idle();
        step();
        check("sf_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle with 3 words stored
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h60 + i);
            step();
        end
        idle();
        check("ar_pre", 32'(count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_dout", 32'(data_out), 32'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef FIFO_PARITY_EN
        wr_en      = 1'b1;
        data_in    = 8'h3C;
        par_inject = 1'b1;
        step();
        par_inject = 1'b0;
        data_in    = 8'h3C;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        check("par_err", 32'(parity_err), 32'd1);
        check("par_valid", 32'(rd_valid), 32'd1);
        check("par_data", 32'(data_out), 32'h3C);
        step();
        check("par_ok", 32'(parity_err), 32'd0);
        check("par_data2", 32'(data_out), 32'h3C);
        idle();
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
